// File: rtl/multdiv_pkg.sv
// Shared types and constants for the mult/div issue and writeback controller.
package multdiv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } md_state_e;

  // Exception writebacks target $rstatus with a per-operation cause code.
  localparam logic [4:0]  RSTATUS_REG = 5'd30;
  localparam logic [31:0] EXC_MULT    = 32'd4;
  localparam logic [31:0] EXC_DIV     = 32'd5;

  function automatic logic [31:0] exc_code(input logic is_div);
    return is_div ? EXC_DIV : EXC_MULT;
  endfunction

endpackage

// File: rtl/md_watchdog.sv
// WAIT-state watchdog: 6-bit cycle counter with a terminal-count flag.
// Only compiled when MULTDIV_TIMEOUT_EN is defined.
`ifdef MULTDIV_TIMEOUT_EN
module md_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  // tc fires in the WAIT cycle whose increment would reach TIMEOUT_CYCLES.
  localparam logic [5:0] Limit = 6'(TIMEOUT_CYCLES - 1);

  logic [5:0] cnt_q, cnt_d;

  // Clear on issue, count each waiting cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 6'd1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = inc_i & (cnt_q == Limit);

endmodule
`endif

// File: rtl/multdiv_ctrl.sv
// Issue/writeback controller for the multi-cycle multiplier/divider.
// Captures an op, pulses start, stalls until result-ready, then writes back
// the result or an exception code to $rstatus.
// Optional WAIT watchdog: define MULTDIV_TIMEOUT_EN.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_is_div,
  input  logic [31:0] in_opA,
  input  logic [31:0] in_opB,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  md_state_e   state_q;
  logic [31:0] op_a_q, op_b_q;
  logic [4:0]  rd_q;
  logic        is_div_q;
  logic        mult_q, div_q;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;

  logic        timeout;
  logic        in_wait, in_issue;

  assign in_wait  = (state_q == StWait);
  assign in_issue = (state_q == StIssue);

`ifdef MULTDIV_TIMEOUT_EN
  md_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_md_watchdog (
    .clk_i(clock),
    .rst_i(reset),
    .clr_i(in_issue),
    .inc_i(in_wait),
    .tc_o (timeout)
  );
`else
  assign timeout = 1'b0;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0) | in_issue;
`endif

  // Writeback that would be produced if WAIT completes this cycle.
  // A real ready wins over a simultaneous timeout.
  logic        fin_exc;
  logic        fin_we;
  logic [4:0]  fin_rd;
  logic [31:0] fin_data;

  // Resolve result vs. exception into the register-file write.
  always_comb begin
    fin_exc  = md_resultRDY ? md_exception : 1'b1;
    fin_rd   = fin_exc ? RSTATUS_REG : rd_q;
    fin_data = fin_exc ? exc_code(is_div_q) : md_result;
    fin_we   = fin_exc | (rd_q != 5'd0);
  end

  // Control FSM with registered start pulses and writeback.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      op_a_q     <= '0;
      op_b_q     <= '0;
      rd_q       <= '0;
      is_div_q   <= 1'b0;
      mult_q     <= 1'b0;
      div_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      // Pulses and writeback last exactly one cycle unless re-armed below.
      mult_q     <= 1'b0;
      div_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      if (flush) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (in_valid) begin
              op_a_q   <= in_opA;
              op_b_q   <= in_opB;
              rd_q     <= in_rd;
              is_div_q <= in_is_div;
              mult_q   <= ~in_is_div;
              div_q    <= in_is_div;
              state_q  <= StIssue;
            end
          end
          // Ready here may be stale from the previous op; never sampled.
          StIssue: begin
            state_q <= StWait;
          end
          StWait: begin
            if (md_resultRDY | timeout) begin
              wb_valid_q <= fin_we;
              wb_rd_q    <= fin_rd;
              wb_data_q  <= fin_data;
              state_q    <= StDone;
            end
          end
          StDone: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign md_operandA  = op_a_q;
  assign md_operandB  = op_b_q;
  assign md_ctrl_MULT = mult_q;
  assign md_ctrl_DIV  = div_q;
  // A flush in DONE must still kill the write.
  assign wb_valid     = wb_valid_q & ~flush;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  // Pipeline advances in DONE so the same instruction is not re-accepted.
  assign stall        = in_valid & (state_q != StDone);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl with a behavioural mult/div model and
// a writeback scoreboard.
module tb_multdiv_ctrl;

  localparam int TimeoutCycles = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_is_div;
  logic [31:0] in_opA;
  logic [31:0] in_opB;
  logic [4:0]  in_rd;
  logic        flush;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;

  // Expected writebacks: {rd, data}
  logic [36:0] sb[$];

  // Model controls
  int model_lat   = 1;
  bit model_never = 1'b0;
  bit stale_rdy   = 1'b0;

  always #5 clock = ~clock;

  multdiv_ctrl #(
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_is_div   (in_is_div),
    .in_opA      (in_opA),
    .in_opB      (in_opB),
    .in_rd       (in_rd),
    .flush       (flush),
    .md_operandA (md_operandA),
    .md_operandB (md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT),
    .md_ctrl_DIV (md_ctrl_DIV),
    .md_result   (md_result),
    .md_exception(md_exception),
    .md_resultRDY(md_resultRDY),
    .stall       (stall),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic idle();
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic drive(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    in_valid  = 1'b1;
    flush     = 1'b0;
    in_is_div = is_div;
    in_opA    = a;
    in_opB    = b;
    in_rd     = rd;
  endtask

  // One op from accept (cycle 0) through DONE; leaves in_valid high so the
  // next call exercises back-to-back acceptance.
  task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat, input bit stale, input bit never);
    int done;
    bit exc;
    bit we;
    exc  = never || (is_div && b == 32'd0);
    we   = exc || (rd != 5'd0);
    done = never ? TimeoutCycles + 2 : lat + 2;
    model_lat   = lat;
    model_never = never;
    tick();
    drive(is_div, a, b, rd);
    stale_rdy = stale;
    if (we) begin
      if (exc) sb.push_back({5'd30, is_div ? 32'd5 : 32'd4});
      else     sb.push_back({rd, is_div ? a / b : a * b});
    end
    for (int c = 0; c <= done; c++) begin
      if (c > 0) begin
        tick();
        if (c == 2) stale_rdy = 1'b0;
      end
      settle();
      chk("md_ctrl_MULT", {31'd0, md_ctrl_MULT}, {31'd0, (c == 1) && !is_div});
      chk("md_ctrl_DIV", {31'd0, md_ctrl_DIV}, {31'd0, (c == 1) && is_div});
      chk("stall", {31'd0, stall}, {31'd0, (c < done)});
      chk("wb_valid", {31'd0, wb_valid}, {31'd0, (c == done) && we});
      if (c >= 1) begin
        chk("md_operandA", md_operandA, a);
        chk("md_operandB", md_operandB, b);
      end
    end
  endtask

  // Behavioural multiplier/divider: ready lat cycles after the start pulse.
  initial begin : model
    int         cnt;
    bit         armed;
    bit         mdiv;
    logic [31:0] ma;
    logic [31:0] mb;
    logic       rdy;
    cnt          = 0;
    armed        = 1'b0;
    mdiv         = 1'b0;
    ma           = '0;
    mb           = '0;
    md_resultRDY = 1'b0;
    md_result    = '0;
    md_exception = 1'b0;
    forever begin
      @(negedge clock);
      if (reset === 1'b1) begin
        armed = 1'b0;
      end else if (md_ctrl_MULT === 1'b1 || md_ctrl_DIV === 1'b1) begin
        armed = !model_never;
        cnt   = model_lat;
        ma    = md_operandA;
        mb    = md_operandB;
        mdiv  = md_ctrl_DIV;
      end
      @(posedge clock);
      #2;
      rdy = 1'b0;
      if (armed) begin
        cnt--;
        if (cnt <= 0) begin
          armed        = 1'b0;
          rdy          = 1'b1;
          md_exception = mdiv && (mb == 32'd0);
          md_result    = mdiv ? ((mb == 32'd0) ? 32'hffff_ffff : ma / mb) : ma * mb;
        end
      end
      md_resultRDY = rdy | stale_rdy;
    end
  end

  // Scoreboard: every wb_valid must match the oldest expected writeback.
  initial begin : monitor
    logic [36:0] exp;
    forever begin
      settle();
      if (wb_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("wb_spurious", {31'd0, wb_valid}, 32'd0);
        end else begin
          exp = sb.pop_front();
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, exp[36:32]});
          chk("wb_data", wb_data, exp[31:0]);
        end
      end
    end
  end

  initial begin : guard
    #2_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_opA"}, md_operandA, 32'd0);
    chk({tag, "_opB"}, md_operandB, 32'd0);
    chk({tag, "_mult"}, {31'd0, md_ctrl_MULT}, 32'd0);
    chk({tag, "_div"}, {31'd0, md_ctrl_DIV}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_wbv"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, "_wbrd"}, {27'd0, wb_rd}, 32'd0);
    chk({tag, "_wbdata"}, wb_data, 32'd0);
  endtask

  initial begin : main
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_is_div = 1'b0;
    in_opA    = '0;
    in_opB    = '0;
    in_rd     = '0;
    flush     = 1'b0;
    repeat (2) tick();
    settle();
    chk_all_zero("reset");
    tick();
    reset = 1'b0;
    tick();

    run_op(1'b0, 32'd6, 32'd7, 5'd3, 32, 1'b0, 1'b0);      // mul 42 -> r3, wb in cycle 34
    run_op(1'b1, 32'd9, 32'd0, 5'd5, 5, 1'b0, 1'b0);       // div by zero -> r30 = 5
    run_op(1'b0, 32'd2, 32'd3, 5'd0, 3, 1'b0, 1'b0);       // rd=0: no write
    run_op(1'b0, 32'd11, 32'd13, 5'd12, 6, 1'b1, 1'b0);    // stale ready in IDLE/ISSUE
    run_op(1'b1, 32'd100, 32'd7, 5'd2, 4, 1'b0, 1'b0);     // div 14 -> r2
    run_op(1'b0, 32'hffff_ffff, 32'd2, 5'd31, 1, 1'b0, 1'b0); // earliest ready, wrap

    // Flush in WAIT: no writeback, new op accepted the very next cycle.
    idle();
    model_lat   = 10;
    model_never = 1'b0;
    tick();
    drive(1'b0, 32'd5, 32'd5, 5'd7);
    repeat (4) tick();
    in_valid = 1'b0;
    flush    = 1'b1;
    settle();
    chk("flush_wait_wbv", {31'd0, wb_valid}, 32'd0);
    run_op(1'b0, 32'd3, 32'd4, 5'd8, 2, 1'b0, 1'b0);

    // Flush in DONE: registered writeback is suppressed.
    idle();
    model_lat = 2;
    tick();
    drive(1'b0, 32'd10, 32'd10, 5'd9);
    repeat (3) tick();
    settle();
    chk("flush_done_pre_stall", {31'd0, stall}, 32'd1);
    tick();
    in_valid = 1'b0;
    flush    = 1'b1;
    settle();
    chk("flush_done_wbv", {31'd0, wb_valid}, 32'd0);
    run_op(1'b0, 32'd8, 32'd8, 5'd10, 1, 1'b0, 1'b0);

`ifdef MULTDIV_TIMEOUT_EN
    run_op(1'b0, 32'd2, 32'd2, 5'd6, 1, 1'b0, 1'b1);       // watchdog -> r30 = 4 in cycle 42
`else
    run_op(1'b0, 32'd1, 32'd1, 5'd4, 60, 1'b0, 1'b0);      // no watchdog: long wait survives
`endif

    // Reset mid-WAIT.
    model_lat   = 30;
    model_never = 1'b0;
    tick();
    drive(1'b0, 32'd3, 32'd3, 5'd11);
    repeat (10) tick();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    settle();
    chk_all_zero("midreset");
    tick();
    reset = 1'b0;
    run_op(1'b1, 32'd50, 32'd5, 5'd13, 3, 1'b0, 1'b0);     // recovery: 10 -> r13

    idle();
    repeat (3) tick();
    settle();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
